// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding select encodings and the hard-wired zero register index.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_fwd_unit.sv
// Combinational register-compare logic: EX-stage forwarding selects and the
// load-use hazard detect between the EX load and the decode-stage sources.
module hazard_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic       MemToRegE,
  input  logic [2:0] RegWriteE,
  input  logic [4:0] RdM,
  input  logic [2:0] RegWriteM,
  input  logic [4:0] RdW,
  input  logic [2:0] RegWriteW,
  output logic       load_use,
  output logic [1:0] Forward1E,
  output logic [1:0] Forward2E
);

  logic mem_wr;
  logic wb_wr;

  // A stage can only forward if it writes a real (non-x0) destination.
  always_comb begin
    mem_wr = (RegWriteM != 3'd0) && (RdM != REG_X0);
    wb_wr  = (RegWriteW != 3'd0) && (RdW != REG_X0);
  end

  // Pick the youngest producer per source: MEM result beats WB result.
  always_comb begin
    Forward1E = FWD_RF;
    Forward2E = FWD_RF;
    if (mem_wr && (RdM == Rs1E))      Forward1E = FWD_MEM;
    else if (wb_wr && (RdW == Rs1E))  Forward1E = FWD_WB;
    if (mem_wr && (RdM == Rs2E))      Forward2E = FWD_MEM;
    else if (wb_wr && (RdW == Rs2E))  Forward2E = FWD_WB;
  end

  // A load in EX whose result is needed by the instruction in decode.
  always_comb begin
    load_use = MemToRegE && (RegWriteE != 3'd0) && (RdE != REG_X0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: data-memory wait
// FSM with watchdog, stall/flush priority mux, forwarding and stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMO_W          = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        MemToRegE,
  input  logic [2:0]  RegWriteE,
  input  logic        BranchTakenE,
  input  logic [4:0]  RdM,
  input  logic [2:0]  RegWriteM,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  input  logic        InstrReqF,
  input  logic        InstrReadyF,
  input  logic [4:0]  RdW,
  input  logic [2:0]  RegWriteW,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        EnW,
  output logic        ClearW,
  output logic [1:0]  Forward1E,
  output logic [1:0]  Forward2E,
  output logic        BusErr,
  output logic [31:0] StallCnt
);

  localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMO_W-1:0] wd_q;
  logic [31:0]      stall_cnt_q;
  logic             load_use;
  logic             dstall;
  logic [1:0]       fwd1;
  logic [1:0]       fwd2;

  hazard_fwd_unit u_fwd (
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .MemToRegE (MemToRegE),
    .RegWriteE (RegWriteE),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .load_use  (load_use),
    .Forward1E (fwd1),
    .Forward2E (fwd2)
  );

  // Data-memory sequencing: wait for ready, trip to ERR when the watchdog expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      wd_q   <= '0;
      BusErr <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wd_q <= '0;
          if (MemReqM && !MemReadyM) state <= DWAIT;
        end
        DWAIT: begin
          if (MemReadyM) begin
            state <= RUN;
            wd_q  <= '0;
          end else if (wd_q == WD_LAST) begin
            state  <= ERR;
            BusErr <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

  // Memory stall is decoded from the live ready so the completing cycle advances.
  always_comb begin
    dstall = ((state == RUN) && MemReqM && !MemReadyM) ||
             ((state == DWAIT) && !MemReadyM) ||
             (state == ERR);
  end

  // Priority mux: reset, memory stall, load-use, taken branch, fetch wait.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    EnW       = 1'b1;
    ClearW    = 1'b0;
    Forward1E = fwd1;
    Forward2E = fwd2;
    if (!rst_n) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ClearW    = 1'b1;
      Forward1E = FWD_RF;
      Forward2E = FWD_RF;
    end else if (dstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      ClearW = 1'b1;
    end else if (load_use && !BranchTakenE) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (InstrReqF && !InstrReadyF) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_cnt_q <= '0;
    else if (StallF && (stall_cnt_q != '1))   stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        MemToRegE, BranchTakenE, MemReqM, MemReadyM, InstrReqF, InstrReadyF;
  logic [2:0]  RegWriteE, RegWriteM, RegWriteW;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, EnW, ClearW, BusErr;
  logic [1:0]  Forward1E, Forward2E;
  logic [31:0] StallCnt;
  logic [7:0]  ctl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, EnW, ClearW};

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TMO), .TMO_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemToRegE(MemToRegE), .RegWriteE(RegWriteE), .BranchTakenE(BranchTakenE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .InstrReqF(InstrReqF), .InstrReadyF(InstrReadyF),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .EnW(EnW), .ClearW(ClearW),
    .Forward1E(Forward1E), .Forward2E(Forward2E),
    .BusErr(BusErr), .StallCnt(StallCnt)
  );

  task automatic set_idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    MemToRegE = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    BranchTakenE = 0; MemReqM = 0; MemReadyM = 0; InstrReqF = 0; InstrReadyF = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    set_idle();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Reference forwarding rule: youngest writing producer of a non-zero register.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [2:0] wm,
                                         input logic [4:0] rdm, input logic [2:0] ww,
                                         input logic [4:0] rdw);
    if (wm != 0 && rdm != 0 && rdm == rs) return 2'b10;
    if (ww != 0 && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    rst_n = 0;
    set_idle();
    RdM = 7; Rs1E = 7; RegWriteM = 1; MemReqM = 1;
    @(negedge clk); #1;
    checks++; if (ctl !== 8'b0000_1111) begin failures++; $display("[TB] FAIL reset_ctl got=%b want=%b", ctl, 8'b0000_1111); end
    checks++; if (Forward1E !== 2'b00) begin failures++; $display("[TB] FAIL reset_fwd got=%b want=00", Forward1E); end
    checks++; if (BusErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_buserr got=%b want=0", BusErr); end
    checks++; if (StallCnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d want=0", StallCnt); end
    set_idle();
    rst_n = 1; #1;
    checks++; if (ctl !== 8'b0000_0010) begin failures++; $display("[TB] FAIL reset_release got=%b want=%b", ctl, 8'b0000_0010); end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    MemToRegE = 1; RegWriteE = 3'b001; RdE = 5; Rs1D = 5; #1;
    checks++; if (ctl !== 8'b1100_0110) begin failures++; $display("[TB] FAIL lu_stall got=%b want=%b", ctl, 8'b1100_0110); end
    @(negedge clk);
    MemToRegE = 0; RegWriteE = 0; RdE = 0; #1;
    checks++; if (ctl !== 8'b0000_0010) begin failures++; $display("[TB] FAIL lu_release got=%b want=%b", ctl, 8'b0000_0010); end
    @(negedge clk);
    MemToRegE = 1; RegWriteE = 3'b001; RdE = 0; Rs1D = 0; #1;
    checks++; if (ctl !== 8'b0000_0010) begin failures++; $display("[TB] FAIL lu_x0 got=%b want=%b", ctl, 8'b0000_0010); end
    @(negedge clk);
    RdE = 9; Rs1D = 3; Rs2D = 9; #1;
    checks++; if (ctl !== 8'b1100_0110) begin failures++; $display("[TB] FAIL lu_rs2 got=%b want=%b", ctl, 8'b1100_0110); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    set_idle();
    RdM = 7; RdW = 7; RegWriteM = 3'b001; RegWriteW = 3'b100; Rs1E = 7; Rs2E = 8; #1;
    checks++; if (Forward1E !== 2'b10) begin failures++; $display("[TB] FAIL fwd_mem got=%b want=10", Forward1E); end
    checks++; if (Forward2E !== 2'b00) begin failures++; $display("[TB] FAIL fwd_none got=%b want=00", Forward2E); end
    RegWriteM = 0; Rs2E = 7; #1;
    checks++; if (Forward1E !== 2'b01) begin failures++; $display("[TB] FAIL fwd_wb got=%b want=01", Forward1E); end
    checks++; if (Forward2E !== 2'b01) begin failures++; $display("[TB] FAIL fwd_wb2 got=%b want=01", Forward2E); end
    RdM = 0; RdW = 0; RegWriteM = 1; Rs1E = 0; #1;
    checks++; if (Forward1E !== 2'b00) begin failures++; $display("[TB] FAIL fwd_x0 got=%b want=00", Forward1E); end
    set_idle();
  endtask

  task automatic test_dmem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      MemReqM = 1; MemReadyM = 0; #1;
      checks++; if (ctl !== 8'b1111_0011) begin failures++; $display("[TB] FAIL dmem_wait%0d got=%b want=%b", i, ctl, 8'b1111_0011); end
    end
    @(negedge clk);
    MemReadyM = 1; #1;
    checks++; if (ctl !== 8'b0000_0010) begin failures++; $display("[TB] FAIL dmem_done got=%b want=%b", ctl, 8'b0000_0010); end
    @(negedge clk);
    set_idle(); MemReqM = 1; MemReadyM = 1; #1;
    checks++; if (ctl !== 8'b0000_0010) begin failures++; $display("[TB] FAIL dmem_run got=%b want=%b", ctl, 8'b0000_0010); end
    checks++; if (StallCnt !== 32'd3) begin failures++; $display("[TB] FAIL dmem_cnt got=%0d want=3", StallCnt); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk);
    BranchTakenE = 1; MemToRegE = 1; RegWriteE = 1; RdE = 5; Rs1D = 5;
    InstrReqF = 1; InstrReadyF = 0; #1;
    checks++; if (ctl !== 8'b0000_1110) begin failures++; $display("[TB] FAIL prio_branch got=%b want=%b", ctl, 8'b0000_1110); end
    @(negedge clk);
    BranchTakenE = 0; #1;
    checks++; if (ctl !== 8'b1100_0110) begin failures++; $display("[TB] FAIL prio_lu_imem got=%b want=%b", ctl, 8'b1100_0110); end
    @(negedge clk);
    MemToRegE = 0; #1;
    checks++; if (ctl !== 8'b1000_1010) begin failures++; $display("[TB] FAIL prio_imem got=%b want=%b", ctl, 8'b1000_1010); end
    @(negedge clk);
    BranchTakenE = 1; MemToRegE = 1; MemReqM = 1; MemReadyM = 0; #1;
    checks++; if (ctl !== 8'b1111_0011) begin failures++; $display("[TB] FAIL prio_dstall got=%b want=%b", ctl, 8'b1111_0011); end
    @(negedge clk);
    set_idle(); MemReadyM = 1; #1;
    checks++; if (ctl !== 8'b0000_0010) begin failures++; $display("[TB] FAIL prio_exit got=%b want=%b", ctl, 8'b0000_0010); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < TMO + 1; k++) begin
      @(negedge clk);
      MemReqM = 1; MemReadyM = 0; #1;
      checks++; if (BusErr !== 1'b0) begin failures++; $display("[TB] FAIL tmo_early%0d got=%b want=0", k, BusErr); end
    end
    @(negedge clk);
    MemReqM = 0; MemReadyM = 1; #1;
    checks++; if (BusErr !== 1'b1) begin failures++; $display("[TB] FAIL tmo_buserr got=%b want=1", BusErr); end
    checks++; if (ctl !== 8'b1111_0011) begin failures++; $display("[TB] FAIL tmo_frozen got=%b want=%b", ctl, 8'b1111_0011); end
    checks++; if (StallCnt !== 32'd5) begin failures++; $display("[TB] FAIL tmo_cnt got=%0d want=5", StallCnt); end
    @(negedge clk); #1;
    checks++; if (ctl !== 8'b1111_0011) begin failures++; $display("[TB] FAIL tmo_frozen2 got=%b want=%b", ctl, 8'b1111_0011); end
    checks++; if (StallCnt !== 32'd6) begin failures++; $display("[TB] FAIL tmo_cnt2 got=%0d want=6", StallCnt); end
    #2 rst_n = 0; #1;
    checks++; if (BusErr !== 1'b0) begin failures++; $display("[TB] FAIL tmo_rst_buserr got=%b want=0", BusErr); end
    checks++; if (StallCnt !== 32'd0) begin failures++; $display("[TB] FAIL tmo_rst_cnt got=%0d want=0", StallCnt); end
    checks++; if (ctl !== 8'b0000_1111) begin failures++; $display("[TB] FAIL tmo_rst_ctl got=%b want=%b", ctl, 8'b0000_1111); end
    @(negedge clk);
    rst_n = 1; set_idle(); MemReqM = 1; MemReadyM = 1; #1;
    checks++; if (ctl !== 8'b0000_0010) begin failures++; $display("[TB] FAIL tmo_run got=%b want=%b", ctl, 8'b0000_0010); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    #1;
    checks++; if (StallCnt !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL sat_preload got=%h want=fffffffe", StallCnt); end
    InstrReqF = 1; InstrReadyF = 0;
    @(negedge clk); #1;
    checks++; if (StallCnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat_top got=%h want=ffffffff", StallCnt); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (StallCnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat_hold got=%h want=ffffffff", StallCnt); end
    set_idle();
  endtask

  task automatic test_random();
    int          m_waits;
    bit          m_err;
    longint      m_cnt;
    bit          ds, lu;
    logic [7:0]  exp_ctl;
    logic [1:0]  e1, e2;
    do_reset();
    m_waits = 0; m_err = 0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      RegWriteE = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      RegWriteM = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      RegWriteW = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      MemToRegE = 1'($urandom_range(0, 1));
      BranchTakenE = ($urandom_range(0, 3) == 0);
      MemReqM = ($urandom_range(0, 2) == 0);
      MemReadyM = ($urandom_range(0, 3) != 0);
      InstrReqF = 1'($urandom_range(0, 1));
      InstrReadyF = 1'($urandom_range(0, 1));
      #1;
      ds = m_err || ((m_waits > 0 || MemReqM) && !MemReadyM);
      lu = MemToRegE && RegWriteE != 0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      if (ds)                            exp_ctl = 8'b1111_0011;
      else if (lu && !BranchTakenE)      exp_ctl = 8'b1100_0110;
      else if (BranchTakenE)             exp_ctl = 8'b0000_1110;
      else if (InstrReqF && !InstrReadyF) exp_ctl = 8'b1000_1010;
      else                               exp_ctl = 8'b0000_0010;
      e1 = ref_fwd(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      e2 = ref_fwd(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("[TB] FAIL rnd_ctl n=%0d got=%b want=%b", n, ctl, exp_ctl); end
      checks++; if (Forward1E !== e1) begin failures++; $display("[TB] FAIL rnd_fwd1 n=%0d got=%b want=%b", n, Forward1E, e1); end
      checks++; if (Forward2E !== e2) begin failures++; $display("[TB] FAIL rnd_fwd2 n=%0d got=%b want=%b", n, Forward2E, e2); end
      checks++; if (BusErr !== m_err) begin failures++; $display("[TB] FAIL rnd_buserr n=%0d got=%b want=%b", n, BusErr, m_err); end
      checks++; if (StallCnt !== 32'(m_cnt)) begin failures++; $display("[TB] FAIL rnd_cnt n=%0d got=%0d want=%0d", n, StallCnt, m_cnt); end
      // Advance the model across the coming clock edge.
      if (exp_ctl[7] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!m_err) begin
        if ((m_waits > 0 || MemReqM) && !MemReadyM) begin
          m_waits++;
          if (m_waits == TMO + 1) m_err = 1;
        end else if (MemReadyM) begin
          m_waits = 0;
        end
      end
    end
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_dmem_wait();
    test_priority();
    test_timeout();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
